// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter and clock master.
// Divides aclk to produce bclk/lrclk, holds one stereo frame behind a
// valid/ready handshake and shifts it out MSB first, left then right.
// Ports:
//   aclk, arst       system clock, synchronous active-high reset
//   enable           run/stop for the serial clocks
//   din_l, din_r     left/right 32-bit samples
//   din_valid        input frame valid
//   din_ready        holding register empty (combinational: ~full & ~arst)
//   bclk, lrclk      serial bit clock and word select (0 = left)
//   dout             serial data, changes on bclk falling edges
//   underrun         one-cycle pulse when a frame starts with nothing held
module i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        enable,
  input  logic [31:0] din_l,
  input  logic [31:0] din_r,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        dout,
  output logic        underrun
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [5:0]       b;
  logic             full;
  logic [31:0]      hold_l;
  logic [31:0]      hold_r;
  logic [63:0]      shift;

  logic             tc;
  logic             fall;
  logic             load;
  logic             xfer;
  logic [5:0]       b_next;
  logic [63:0]      frame;

  // Divider terminal count; a fall is the terminal count while bclk is high.
  assign tc     = enable && (div == DIV_LAST);
  assign fall   = tc && bclk;
  assign load   = fall && (b == 6'd63);
  assign b_next = b + 6'd1;

  assign din_ready = ~full & ~arst;
  assign xfer      = din_valid && din_ready;

  // Frame presented at the load: held data, or silence on underrun.
  assign frame = full ? {hold_l, hold_r} : 64'h0;

  // Divider, bit counter, serialiser and handshake.
  always_ff @(posedge aclk) begin
    if (arst) begin
      div      <= '0;
      b        <= 6'd63;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      dout     <= 1'b0;
      underrun <= 1'b0;
      full     <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      shift    <= '0;
    end else begin
      underrun <= 1'b0;

      if (!enable) begin
        // Stopped: abandon the current frame so re-enable starts at b=0.
        div   <= '0;
        b     <= 6'd63;
        bclk  <= 1'b0;
        lrclk <= 1'b0;
        dout  <= 1'b0;
        shift <= '0;
      end else if (tc) begin
        div  <= '0;
        bclk <= ~bclk;
        if (bclk) begin
          b     <= b_next;
          // Word select leads each word's MSB by one bit.
          lrclk <= (b_next >= 6'd31) && (b_next <= 6'd62);
          if (b == 6'd63) begin
            dout     <= frame[63];
            shift    <= {frame[62:0], 1'b0};
            underrun <= ~full;
          end else begin
            dout  <= shift[63];
            shift <= {shift[62:0], 1'b0};
          end
        end
      end else begin
        div <= div + DIV_W'(1);
      end

      // A transfer needs full=0, so it never collides with a clearing load.
      if (xfer) begin
        hold_l <= din_l;
        hold_r <= din_r;
        full   <= 1'b1;
      end else if (load) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx. A frame-level reference model
// predicts outputs every cycle, and a bench-side I2S receiver decodes the
// serial stream back into frames for comparison against sent data.
module tb_i2s_tx;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 128 * DIV;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] din_l = '0;
  logic [31:0] din_r = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        bclk;
  logic        lrclk;
  logic        dout;
  logic        underrun;

  i2s_tx #(.BCLK_DIV(DIV)) dut (
    .aclk      (aclk),
    .arst      (arst),
    .enable    (enable),
    .din_l     (din_l),
    .din_r     (din_r),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .dout      (dout),
    .underrun  (underrun)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Reference model: time since enable determines bclk phase and bit index.
  int unsigned m_t = 0;
  int unsigned m_idx = 0;
  logic        m_full = 1'b0;
  logic        m_xfer = 1'b0;
  logic [63:0] m_hold = '0;
  logic [63:0] m_frame = '0;
  logic        e_bclk = 1'b0;
  logic        e_lrclk = 1'b0;
  logic        e_dout = 1'b0;
  logic        e_und = 1'b0;
  logic [63:0] exp_q[$];

  initial forever begin
    @(posedge aclk);
    m_xfer = 1'b0;
    e_und  = 1'b0;
    if (arst) begin
      m_t = 0; m_full = 1'b0; m_hold = '0; m_frame = '0;
      e_bclk = 1'b0; e_lrclk = 1'b0; e_dout = 1'b0;
      exp_q.delete();
    end else begin
      m_xfer = din_valid && !m_full;
      if (!enable) begin
        m_t = 0; e_bclk = 1'b0; e_lrclk = 1'b0; e_dout = 1'b0;
      end else begin
        m_t++;
        if (m_t % DIV == 0) begin
          e_bclk = ((m_t / DIV) % 2) == 1;
          if (!e_bclk) begin
            m_idx = ((m_t / (2 * DIV)) - 1) % 64;
            if (m_idx == 0) begin
              if (m_full) begin m_frame = m_hold; m_full = 1'b0; end
              else begin m_frame = '0; e_und = 1'b1; end
            end
            e_dout  = m_frame[63 - m_idx];
            e_lrclk = (m_idx >= 31) && (m_idx <= 62);
            if (m_idx == 63) exp_q.push_back(m_frame);
          end
        end
      end
      if (m_xfer) begin m_hold = {din_l, din_r}; m_full = 1'b1; end
    end
  end

  // Per-cycle output check plus bench-side I2S receiver.
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b0;
  logic        rx_have_left = 1'b0;
  logic [31:0] rx_sr = '0;
  logic [31:0] rx_left = '0;
  logic [63:0] rx_log[$];
  logic [63:0] rx_exp;
  logic [4:0]  got_o;
  logic [4:0]  want_o;
  int          und_seen = 0;

  initial forever begin
    @(negedge aclk);
    got_o  = {bclk, lrclk, dout, underrun, din_ready};
    want_o = {e_bclk, e_lrclk, e_dout, e_und, !m_full && !arst};
    checks++;
    if (got_o !== want_o) begin
      errors++;
      $display("FAIL outputs t=%0t bclk/lrclk/dout/und/rdy got %b want %b", $time, got_o, want_o);
    end
    if (arst) begin
      rx_log.delete(); und_seen = 0;
      rx_have_left = 1'b0; prev_lr = 1'b0; rx_sr = '0;
    end else begin
      if (underrun === 1'b1) und_seen++;
      if (!enable) begin
        rx_have_left = 1'b0; prev_lr = 1'b0; rx_sr = '0;
      end else if (bclk && !prev_bclk) begin
        rx_sr = {rx_sr[30:0], dout};
        if (lrclk != prev_lr) begin
          if (lrclk) begin
            rx_left = rx_sr; rx_have_left = 1'b1;
          end else if (rx_have_left) begin
            rx_have_left = 1'b0;
            rx_log.push_back({rx_left, rx_sr});
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_frame got %h want <none expected>", {rx_left, rx_sr});
            end else begin
              rx_exp = exp_q.pop_front();
              if ({rx_left, rx_sr} !== rx_exp) begin
                errors++;
                $display("FAIL rx_frame got %h want %h", {rx_left, rx_sr}, rx_exp);
              end
            end
          end
          prev_lr = lrclk;
        end
      end
    end
    prev_bclk = bclk;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic do_reset(input logic en);
    arst = 1'b1; enable = en; din_valid = 1'b0;
    tick(3);
    arst = 1'b0;
  endtask

  task automatic wait_xfer(input string name, input int bound);
    int n;
    n = 0;
    tick(1);
    while (!m_xfer && n < bound) begin tick(1); n++; end
    if (!m_xfer) begin
      checks++; errors++;
      $display("FAIL %s timeout got no transfer want transfer", name);
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int cnt, input int bound);
    int n;
    n = 0;
    while (rx_log.size() < cnt && n < bound) begin tick(1); n++; end
    if (rx_log.size() < cnt) begin
      checks++; errors++;
      $display("FAIL %s timeout got %0d frames want %0d", name, rx_log.size(), cnt);
    end
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    din_l = l; din_r = r; din_valid = 1'b1;
  endtask

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  localparam int NVEC = 5;
  vec_t tbl[NVEC];
  logic [63:0] sent_q[$];
  logic [63:0] nz_q[$];
  logic [31:0] cnt;
  logic [31:0] rl;
  logic [31:0] rr;

  initial begin
    tbl[0] = '{32'h8000_0001, 32'h7FFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFE};
    tbl[1] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
    tbl[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0};

    // Reset with enable held high, then divider start-up.
    do_reset(1'b1);
    arst = 1'b1;
    tick(1);
    chk("reset_outputs", 64'({bclk, lrclk, dout, underrun, din_ready}), 64'h0);
    arst = 1'b0;
    tick(1);
    chk("ready_after_reset", 64'(din_ready), 64'h1);
    tick(2);
    chk("bclk_low_t3", 64'(bclk), 64'h0);
    tick(1);
    chk("bclk_rise_t4", 64'(bclk), 64'h1);
    tick(4);
    chk("bclk_fall_t8", 64'(bclk), 64'h0);

    // Table-driven frames through the serial stream, no gaps.
    do_reset(1'b0);
    send(tbl[0].l, tbl[0].r);
    wait_xfer("tbl_w0", 10);
    enable = 1'b1;
    for (int i = 1; i < NVEC; i++) begin
      send(tbl[i].l, tbl[i].r);
      wait_xfer("tbl_w", 2 * FRAME);
    end
    wait_rx("tbl_rx", NVEC, 3 * FRAME);
    for (int i = 0; i < NVEC; i++) begin
      if (i < rx_log.size())
        chk($sformatf("tbl_frame%0d", i), rx_log[i], {tbl[i].exp_l, tbl[i].exp_r});
    end
    chk("tbl_no_underrun", 64'(und_seen), 64'h0);

    // Underrun at the first load, then a mid-frame write.
    do_reset(1'b0);
    enable = 1'b1;
    tick(2 * DIV);
    chk("und_pulse", 64'(underrun), 64'h1);
    tick(1);
    chk("und_width", 64'(underrun), 64'h0);
    tick(100);
    send(32'hA5A5_A5A5, 32'h0F0F_0F0F);
    wait_xfer("und_w", 10);
    wait_rx("und_rx", 2, 3 * FRAME);
    if (rx_log.size() >= 2) begin
      chk("und_zero_frame", rx_log[0], 64'h0);
      chk("und_next_frame", rx_log[1], 64'hA5A5_A5A5_0F0F_0F0F);
    end
    chk("und_count", 64'(und_seen), 64'h1);

    // Transfer in the same cycle as an empty load.
    do_reset(1'b0);
    enable = 1'b1;
    tick(2 * DIV - 1);
    send(32'hDEAD_BEEF, 32'hCAFE_F00D);
    tick(1);
    din_valid = 1'b0;
    chk("sim_underrun", 64'(underrun), 64'h1);
    chk("sim_full", 64'(din_ready), 64'h0);
    wait_rx("sim_rx", 2, 3 * FRAME);
    if (rx_log.size() >= 2) begin
      chk("sim_zero_frame", rx_log[0], 64'h0);
      chk("sim_data_frame", rx_log[1], 64'hDEAD_BEEF_CAFE_F00D);
    end

    // Drop enable at b=40; held frame resumes from b=0.
    do_reset(1'b0);
    send(32'h1111_1111, 32'h2222_2222);
    wait_xfer("en_w1", 10);
    enable = 1'b1;
    tick(2 * DIV);
    send(32'h3333_3333, 32'h4444_4444);
    tick(1);
    din_valid = 1'b0;
    tick(2 * DIV * 41 - (2 * DIV + 1));
    chk("en_lrclk_b40", 64'(lrclk), 64'h1);
    enable = 1'b0;
    tick(1);
    chk("en_off_outputs", 64'({bclk, lrclk, dout}), 64'h0);
    chk("en_hold_kept", 64'(din_ready), 64'h0);
    tick(10);
    enable = 1'b1;
    wait_rx("en_rx", 1, 2 * FRAME);
    if (rx_log.size() >= 1) chk("en_held_frame", rx_log[0], 64'h3333_3333_4444_4444);
    chk("en_no_underrun", 64'(und_seen), 64'h0);

    // Back-pressure: valid held high with an incrementing counter.
    do_reset(1'b0);
    cnt = 32'd0;
    send(cnt, cnt + 32'h1000);
    enable = 1'b1;
    for (int n = 0; n < 10 * FRAME && rx_log.size() < 8; n++) begin
      tick(1);
      if (m_xfer) begin cnt++; din_l = cnt; din_r = cnt + 32'h1000; end
    end
    din_valid = 1'b0;
    chk("bp_frames", 64'(rx_log.size() >= 8), 64'h1);
    for (int i = 0; i < 8; i++) begin
      if (i < rx_log.size())
        chk($sformatf("bp_frame%0d", i), rx_log[i], {32'(i), 32'(i) + 32'h1000});
    end
    chk("bp_no_underrun", 64'(und_seen), 64'h0);

    // Random loopback with random gaps between writes.
    do_reset(1'b1);
    sent_q.delete();
    for (int i = 0; i < 16; i++) begin
      tick($urandom_range(0, 700));
      rl = $urandom; rr = $urandom;
      sent_q.push_back({rl, rr});
      send(rl, rr);
      wait_xfer("rnd_w", 4 * FRAME);
    end
    tick(3 * FRAME);
    nz_q.delete();
    foreach (rx_log[i]) if (rx_log[i] != 64'h0) nz_q.push_back(rx_log[i]);
    chk("rnd_count", 64'(nz_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < nz_q.size()) chk($sformatf("rnd_frame%0d", i), nz_q[i], sent_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parameterised I2S transmitter, the output-side counterpart of the I2S receiver in the DAC datapath. It accepts stereo 32-bit PCM frames over a valid/ready handshake, holds one frame in a holding register, and serialises it as standard Philips I2S. The block generates BCLK and LRCLK itself by dividing ACLK, so it is the clock master. It drives a downstream codec or loopback into the receiver.

## Interface
- BCLK_DIV, 4, ACLK cycles per BCLK half-period; legal values ≥ 2.
- ACLK  in  1  system clock; all logic is synchronous to its rising edge.
- ARST  in  1  reset; synchronous, active-high.
- ENABLE  in  1  run/stop for the serial clocks.
- DIN_L  in  32  left sample, MSB first on the wire.
- DIN_R  in  32  right sample.
- DIN_VALID  in  1  DIN_L/DIN_R are valid.
- DIN_READY  out  1  the holding register is empty; the block can accept a frame.
- BCLK  out  1  serial bit clock.
- LRCLK  out  1  word select: 0 = left, 1 = right.
- DOUT  out  1  serial data.
- UNDERRUN  out  1  one-ACLK pulse when a frame starts with the holding register empty.

## Operation
- **Divider.** A counter `div` runs 0..BCLK_DIV-1 while ENABLE=1. At terminal count it wraps and toggles BCLK.
  - The toggle 0→1 is a BCLK rising edge.
  - The toggle 1→0 is a BCLK falling edge, called "fall" below.
- **Bit counter.** `b` (6 bits) increments on each fall and wraps 63→0.
- **Outputs change only on fall.** The receiver samples on the BCLK rising edge.
  - LRCLK = 1 when b is in 31..62, else 0. LRCLK therefore leads each word's MSB by one BCLK.
- **Frame load.** At the fall where b wraps 63→0:
  - The 64-bit shift register loads {HOLD_L, HOLD_R} if `full`=1, then `full` is cleared.
  - Otherwise it loads 64'h0 and UNDERRUN pulses in that same ACLK cycle.
  - At every fall, DOUT takes the shift-register MSB and the register shifts left, filling with 0.
  - Result: left MSB at b=0, left LSB at b=31, right MSB at b=32, right LSB at b=63.
- **Handshake.**
  - DIN_READY = ~full & ~ARST.
  - A transfer happens when DIN_VALID & DIN_READY. It captures DIN_L/DIN_R into HOLD and sets `full` on the next edge.
  - DIN_VALID may stay high; exactly one frame is taken per transfer.
- **Simultaneous events.**
  - Transfer in the same cycle as a frame load with `full`=0: the load emits zeros and UNDERRUN. The new data sets `full` and goes out in the following frame.
  - A frame load with `full`=1 blocks any transfer in that cycle, because DIN_READY=0.
- **ENABLE=0.** Takes effect on the next edge: div=0, b=63, BCLK=0, LRCLK=0, DOUT=0, shift register cleared.
  - HOLD and `full` are retained, and the handshake remains active.
  - If ENABLE drops mid-frame, the current frame is abandoned and no UNDERRUN is raised.
  - On re-enable, the first fall starts a new frame (b→0).
- **Reset.** At the edge with ARST=1: BCLK=0, LRCLK=0, DOUT=0, UNDERRUN=0, div=0, b=63, `full`=0, HOLD=0, shift=0. DIN_READY=0 while ARST is high.

## Timing
- BCLK period = 2·BCLK_DIV ACLK cycles.
- Frame = 64 BCLK = 128·BCLK_DIV ACLK cycles (512 with the default).
- After ENABLE rises with `div` at 0, the first BCLK rise occurs BCLK_DIV cycles later. The first fall, which loads frame 0, occurs 2·BCLK_DIV cycles later.
- Latency: a frame accepted before fall k of b=63→0 appears on DOUT starting at that fall. DIN_READY returns to 1 in the ACLK cycle after the load.
- All outputs are registered; no combinational path from inputs to BCLK/LRCLK/DOUT/UNDERRUN.
- DOUT and LRCLK are stable for BCLK_DIV cycles before and after each BCLK rise.

## Test plan
- **Reset.** ARST high for 3 cycles with ENABLE=1. Require all outputs 0 and DIN_READY=0. Release: DIN_READY=1 next cycle; BCLK toggles every 4 cycles (BCLK_DIV=4).
- **Single frame.** Write L=32'h8000_0001, R=32'h7FFF_FFFE before the first load. At BCLK rises, DOUT must read 1, then 30×0, then 1, then 0, then 30×1, then 0. LRCLK=0 for left bits and 1 for right bits, with transitions one BCLK before each MSB. No UNDERRUN.
- **Underrun.** Enable with no write. Require an UNDERRUN pulse at the first load, exactly one ACLK wide, with DOUT all zeros. Write L=32'hA5A5A5A5 mid-frame; it must appear in the next frame with no UNDERRUN.
- **Back-pressure.** Hold DIN_VALID high with an incrementing counter on L/R. Require one transfer per frame, DIN_READY low between the load and the next cycle, and no skipped or duplicated values over 8 frames.
- **Simultaneous.** Assert the first valid exactly in the load cycle. Require UNDERRUN plus a zero frame, then the data in the next frame.
- **ENABLE toggle.** Drop ENABLE at b=40. Require BCLK/LRCLK/DOUT=0 on the next edge and HOLD kept. On re-enable, the held frame is output from b=0.
- **Loopback.** Connect to the I2S receiver for 16 random frames. Require DOUT_L/DOUT_R to match the sent frames in order.
